// File: rtl/prf_wb_arbiter_if.sv
// Result-bus request channel between the functional units and the PRF write-port arbiter.
// Slices of req_preg/req_data are packed per requester, index i at [i*W +: W].
interface prf_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int PREG_W  = 7,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PREG_W-1:0] req_preg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_preg,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_preg,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/prf_wb_arbiter.sv
// Round-robin arbiter sharing the single PRF write port among the result buses,
// with a registered write/wakeup stage and a saturating contention counter.
module prf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PREG_W  = 7,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    prf_wb_arbiter_if.slave    bus,
    output logic               prf_we,
    output logic [PREG_W-1:0]  prf_waddr,
    output logic [DATA_W-1:0]  prf_wdata,
    output logic               wb_tag_valid,
    output logic [PREG_W-1:0]  wb_tag,
    output logic [CNT_W-1:0]   contention_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic               grant_any;
    logic               handshake;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [PREG_W-1:0]  win_preg;
    logic [DATA_W-1:0]  win_data;
    logic               seen_one;
    logic               contended;
    int                 scan_sum;

    // Scan req_valid from rr_ptr upward with wrap; the first valid index wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = 0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = int'(rr_ptr) + k;
            if (scan_sum >= NUM_REQ) begin
                scan_sum = scan_sum - NUM_REQ;
            end
            scan_idx = IDX_W'(scan_sum);
            if (!grant_any && bus.req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        win_preg     = '0;
        win_data     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_any && (grant_idx == IDX_W'(i))) begin
                grant_onehot[i] = 1'b1;
                win_preg        = bus.req_preg[i*PREG_W +: PREG_W];
                win_data        = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready is suppressed while reset is held so no handshake completes then.
    assign handshake     = grant_any && !reset;
    assign bus.req_ready = reset ? '0 : grant_onehot;

    always_comb begin
        if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + IDX_W'(1);
        end
    end

    always_comb begin
        seen_one  = 1'b0;
        contended = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i]) begin
                if (seen_one) begin
                    contended = 1'b1;
                end
                seen_one = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= ptr_next;
        end
    end

    // Writes to p0 (the x0 mapping) complete the handshake but never reach the PRF.
    always_ff @(posedge clk) begin
        if (reset) begin
            prf_we       <= 1'b0;
            prf_waddr    <= '0;
            prf_wdata    <= '0;
            wb_tag_valid <= 1'b0;
            wb_tag       <= '0;
        end else if (handshake) begin
            prf_we       <= (win_preg != '0);
            prf_waddr    <= win_preg;
            prf_wdata    <= win_data;
            wb_tag_valid <= (win_preg != '0);
            wb_tag       <= win_preg;
        end else begin
            prf_we       <= 1'b0;
            wb_tag_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            contention_cnt <= '0;
        end else if (contended && (contention_cnt != {CNT_W{1'b1}})) begin
            contention_cnt <= contention_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Scoreboard bench for prf_wb_arbiter: a rotating-priority reference model predicts
// grants, write-stage contents and two counter widths; a negedge monitor compares.
module tb_prf_wb_arbiter;

    localparam int N  = 3;
    localparam int PW = 7;
    localparam int DW = 32;

    typedef struct {
        logic [N-1:0] ready;
        logic [15:0]  cnt16;
        logic [3:0]   cnt4;
        bit           chk_regs;
    } exp_t;

    typedef struct {
        int            stamp;
        logic [PW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk;
    logic reset;

    logic          prf_we,    prf_we4;
    logic [PW-1:0] prf_waddr, prf_waddr4;
    logic [DW-1:0] prf_wdata, prf_wdata4;
    logic          wb_tag_valid, wb_tag_valid4;
    logic [PW-1:0] wb_tag,    wb_tag4;
    logic [15:0]   contention_cnt;
    logic [3:0]    contention_cnt4;

    prf_wb_arbiter_if #(.NUM_REQ(N), .PREG_W(PW), .DATA_W(DW)) bus  ();
    prf_wb_arbiter_if #(.NUM_REQ(N), .PREG_W(PW), .DATA_W(DW)) bus4 ();

    assign bus4.req_valid = bus.req_valid;
    assign bus4.req_preg  = bus.req_preg;
    assign bus4.req_data  = bus.req_data;

    prf_wb_arbiter #(.NUM_REQ(N), .PREG_W(PW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .prf_we         (prf_we),
        .prf_waddr      (prf_waddr),
        .prf_wdata      (prf_wdata),
        .wb_tag_valid   (wb_tag_valid),
        .wb_tag         (wb_tag),
        .contention_cnt (contention_cnt)
    );

    prf_wb_arbiter #(.NUM_REQ(N), .PREG_W(PW), .DATA_W(DW), .CNT_W(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus4),
        .prf_we         (prf_we4),
        .prf_waddr      (prf_waddr4),
        .prf_wdata      (prf_wdata4),
        .wb_tag_valid   (wb_tag_valid4),
        .wb_tag         (wb_tag4),
        .contention_cnt (contention_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int           m_ptr     = 0;
    int           m_cnt16   = 0;
    int           m_cnt4    = 0;
    int           last_grant = -1;
    logic [N-1:0]    cur_v = '0;
    logic [N*PW-1:0] cur_p = '0;
    logic [N*DW-1:0] cur_d = '0;

    function automatic void check_output(input string name, input logic [63:0] act,
                                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Drives one cycle of requests and records what the reference model predicts for it.
    task automatic apply_stimulus(input logic [N-1:0] v, input logic [N*PW-1:0] p,
                                  input logic [N*DW-1:0] d, input bit rst);
        exp_t e;
        wr_t  w;
        int   idx;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.req_valid = v;
        bus.req_preg  = p;
        bus.req_data  = d;
        cur_v = v;
        cur_p = p;
        cur_d = d;
        cyc++;
        e.chk_regs = (cyc > 1);
        e.cnt16    = 16'(m_cnt16);
        e.cnt4     = 4'(m_cnt4);
        e.ready    = '0;
        last_grant = -1;
        if (rst) begin
            m_ptr   = 0;
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (last_grant < 0 && v[idx]) last_grant = idx;
            end
            if (last_grant >= 0) begin
                e.ready[last_grant] = 1'b1;
                if (p[last_grant*PW +: PW] != '0) begin
                    w.stamp = cyc + 1;
                    w.addr  = p[last_grant*PW +: PW];
                    w.data  = d[last_grant*DW +: DW];
                    wr_q.push_back(w);
                end
                m_ptr = (last_grant + 1) % N;
            end
            if ($countones(v) >= 2) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
        exp_q.push_back(e);
    endtask

    exp_t mon_e;
    wr_t  mon_w;
    bit   mon_want;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_output("req_ready", 64'(bus.req_ready), 64'(mon_e.ready));
            check_output("req_ready_cnt4", 64'(bus4.req_ready), 64'(mon_e.ready));
            if (mon_e.chk_regs) begin
                mon_want = (wr_q.size() > 0) && (wr_q[0].stamp == cyc);
                check_output("prf_we", 64'(prf_we), 64'(mon_want));
                check_output("wb_tag_valid", 64'(wb_tag_valid), 64'(mon_want));
                if (mon_want) begin
                    mon_w = wr_q.pop_front();
                    check_output("prf_waddr", 64'(prf_waddr), 64'(mon_w.addr));
                    check_output("prf_wdata", 64'(prf_wdata), 64'(mon_w.data));
                    check_output("wb_tag", 64'(wb_tag), 64'(mon_w.addr));
                end
                check_output("contention_cnt", 64'(contention_cnt), 64'(mon_e.cnt16));
                check_output("contention_cnt_w4", 64'(contention_cnt4), 64'(mon_e.cnt4));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    localparam logic [N*PW-1:0] P_ALL = {7'd30, 7'd20, 7'd10};
    localparam logic [N*DW-1:0] D_ALL = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

    initial begin
        logic [N-1:0]    nv;
        logic [N*PW-1:0] np;
        logic [N*DW-1:0] nd;
        bit              nrst;

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_preg  = '0;
        bus.req_data  = '0;

        // reset held with every requester asserting valid
        apply_stimulus(3'b111, P_ALL, D_ALL, 1'b1);
        apply_stimulus(3'b111, P_ALL, D_ALL, 1'b1);
        apply_stimulus(3'b000, '0, '0, 1'b0);

        // single requester, p5 <- DEADBEEF
        apply_stimulus(3'b001, {7'd0, 7'd0, 7'd5}, {64'h0, 32'hDEAD_BEEF}, 1'b0);
        apply_stimulus(3'b000, '0, '0, 1'b0);

        // round-robin from a fresh reset, all valid for six cycles
        apply_stimulus(3'b000, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) apply_stimulus(3'b111, P_ALL, D_ALL, 1'b0);
        apply_stimulus(3'b000, '0, '0, 1'b0);

        // pointer skip and wrap: bring pointer to 2, then 011 -> 0, then 010 -> 1
        apply_stimulus(3'b001, P_ALL, D_ALL, 1'b0);
        apply_stimulus(3'b010, P_ALL, D_ALL, 1'b0);
        apply_stimulus(3'b011, P_ALL, D_ALL, 1'b0);
        apply_stimulus(3'b010, P_ALL, D_ALL, 1'b0);

        // x0 destination from pointer 1; 011 afterwards exposes whether the pointer moved
        apply_stimulus(3'b001, P_ALL, D_ALL, 1'b0);
        apply_stimulus(3'b010, {7'd0, 7'd0, 7'd0}, {32'h0, 32'h0000_1234, 32'h0}, 1'b0);
        apply_stimulus(3'b011, P_ALL, D_ALL, 1'b0);
        apply_stimulus(3'b000, '0, '0, 1'b0);

        // 20 contended cycles: the 4-bit counter must stick at 15
        apply_stimulus(3'b000, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++) apply_stimulus(3'b111, P_ALL, D_ALL, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(3'b000, '0, '0, 1'b0);

        // random traffic; losing requesters hold their request until granted
        for (int c = 0; c < 600; c++) begin
            nv = cur_v;
            np = cur_p;
            nd = cur_d;
            for (int i = 0; i < N; i++) begin
                if (!(cur_v[i] && last_grant != i)) begin
                    nv[i] = ($urandom_range(0, 99) < 60);
                    np[i*PW +: PW] = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
                    nd[i*DW +: DW] = $urandom;
                end
            end
            nrst = ($urandom_range(0, 99) < 2);
            apply_stimulus(nv, np, nd, nrst);
        end

        for (int i = 0; i < 3; i++) apply_stimulus(3'b000, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        check_output("write_queue_drained", 64'(wr_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prf_wb_arbiter.md
Name: prf_wb_arbiter

Overview:
- Shares the single physical-register-file write port between NUM_REQ functional-unit result buses (default: ALU, LSU, branch unit).
- Grants one requester per cycle using round-robin priority with a valid/ready handshake.
- Registers the winner into a one-cycle write stage that drives the PRF write port and the wakeup tag broadcast to the issue queues.
- Counts contention cycles for performance debug.

Parameters:
- NUM_REQ, 3, number of result-bus requesters (2..8)
- PREG_W, 7, physical register index width (128 physical registers)
- DATA_W, 32, result data width
- CNT_W, 16, width of the contention counter

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  requester i holds a result
- req_preg  input  NUM_REQ*PREG_W  destination physical register, slice i
- req_data  input  NUM_REQ*DATA_W  result data, slice i
- req_ready  output  NUM_REQ  one-hot grant; handshake completes when valid[i]&ready[i]
- prf_we  output  1  PRF write enable (registered)
- prf_waddr  output  PREG_W  PRF write index (registered)
- prf_wdata  output  DATA_W  PRF write data (registered)
- wb_tag_valid  output  1  wakeup broadcast valid (registered)
- wb_tag  output  PREG_W  wakeup broadcast tag (registered)
- contention_cnt  output  CNT_W  cycles in which more than one requester was valid

Behaviour:
- Reset (synchronous, active-high) clears the following:
  - rr_ptr=0
  - prf_we=0, prf_waddr=0, prf_wdata=0
  - wb_tag_valid=0, wb_tag=0
  - contention_cnt=0
- On reset, req_ready is 0 for that cycle.
- Grant is combinational in the same cycle:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first valid index g gets req_ready[g]=1. All other ready bits are 0.
  - No valid requester means req_ready=0.
  - req_ready never depends on itself and has no path from outputs.
- rr_ptr update on a grant: rr_ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0. Without a grant, rr_ptr holds.
- Write stage, registered, with 1-cycle latency from handshake to prf_we:
  - On a grant with req_preg[g]!=0: prf_we=1, prf_waddr=req_preg[g], prf_wdata=req_data[g], wb_tag_valid=1, wb_tag=req_preg[g].
  - On a grant with req_preg[g]==0 (the x0 mapping): the handshake still completes and rr_ptr still advances, but prf_we=0 and wb_tag_valid=0. Addr and data registers still load.
  - With no grant: prf_we=0 and wb_tag_valid=0. Addr and data hold their previous values.
- Requester protocol: a requester that is not granted must keep valid, preg and data stable until it is granted. The arbiter does not buffer losing requests.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- contention_cnt increments when popcount(req_valid)>=2, saturates at all-ones, and does not wrap.
- Reset in mid-operation: a pending write-stage entry is discarded (prf_we=0 on the next cycle) and pending requests see ready=0.

Test Plan:
- Reset → outputs: hold reset 2 cycles with all req_valid=1 → req_ready=000 during reset; prf_we=0, wb_tag_valid=0, contention_cnt=0 after reset.
- Single requester: req_valid=001, preg=7'd5, data=32'hDEADBEEF → req_ready=001 in the same cycle; next cycle prf_we=1, prf_waddr=5, prf_wdata=DEADBEEF, wb_tag=5.
- Round-robin: all three valid and held for 6 cycles from reset → grants 0,1,2,0,1,2; contention_cnt=6; PRF writes appear in the same order, each one cycle later.
- Pointer wrap / skip: rr_ptr=2 and req_valid=011 → grant index 0, rr_ptr becomes 1. Next cycle req_valid=010 → grant 1, rr_ptr wraps to 2.
- x0 destination: req_valid=010, preg=0, data=32'h1234 → req_ready=010; next cycle prf_we=0, wb_tag_valid=0; rr_ptr still advances to 2.
- Counter saturation with CNT_W=4: 20 contended cycles → contention_cnt stops at 15 and never reads 0 again until reset.
